pipe_ctrl: RTL

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stalls, mispredict flushes, halt drain.
// Latency: outputs are combinational from state and inputs; state moves on rising clk.
// Backpressure: stalls hold PC and IF/ID; flushes insert bubbles; HALTED holds until reset.
// Optional statistics counters are enabled by defining PIPE_CTRL_STATS_EN.
module pipe_ctrl #(
  parameter int LU_STALL  = 1,
  parameter int FLUSH_LEN = 1,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             ex_memread,
  input  logic [4:0]       ex_rd,
  input  logic             ex_branch,
  input  logic             correct_b,
  input  logic             halt_id,
  input  logic             wb_halt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             halted,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    STALL  = 3'd1,
    FLUSH  = 3'd2,
    DRAIN  = 3'd3,
    HALTED = 3'd4
  } state_t;

  // Sub-counter preload values: the RUN cycle that detects the event is the
  // first bubble, so the extra state covers the remaining N-1 cycles.
  localparam logic [2:0] LU_LOAD = (LU_STALL  > 1) ? 3'(LU_STALL  - 2) : 3'd0;
  localparam logic [2:0] FL_LOAD = (FLUSH_LEN > 1) ? 3'(FLUSH_LEN - 2) : 3'd0;

  state_t     cur_state, nxt_state;
  logic [2:0] sub_q, sub_d;
  logic       mispredict, load_use;

  assign mispredict = ex_branch & ~correct_b;
  assign load_use   = ex_memread & (ex_rd != 5'd0) &
                      ((id_use_rs & (id_rs == ex_rd)) | (id_use_rt & (id_rt == ex_rd)));

  assign state  = cur_state;
  assign halted = (cur_state == HALTED);

  // State register and bubble sub-counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_state <= RUN;
      sub_q     <= 3'd0;
    end else begin
      cur_state <= nxt_state;
      sub_q     <= sub_d;
    end
  end

  // Next-state and hazard control outputs.
  always_comb begin
    nxt_state  = cur_state;
    sub_d      = sub_q;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    case (cur_state)
      RUN: begin
        if (mispredict) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (FLUSH_LEN > 1) begin
            nxt_state = FLUSH;
            sub_d     = FL_LOAD;
          end
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          idex_flush = 1'b1;
          if (LU_STALL > 1) begin
            nxt_state = STALL;
            sub_d     = LU_LOAD;
          end
        end else if (halt_id) begin
          pc_en      = 1'b0;
          ifid_flush = 1'b1;
          nxt_state  = DRAIN;
        end
      end
      STALL: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
        if (sub_q == 3'd0) nxt_state = RUN;
        else               sub_d     = sub_q - 3'd1;
      end
      FLUSH: begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        if (sub_q == 3'd0) nxt_state = RUN;
        else               sub_d     = sub_q - 3'd1;
      end
      DRAIN: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b1;
        if (wb_halt) nxt_state = HALTED;
      end
      HALTED: begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end
      default: begin
        nxt_state = RUN;
        sub_d     = 3'd0;
      end
    endcase
  end

`ifdef PIPE_CTRL_STATS_EN
  logic             stall_evt, flush_evt;
  logic [CNT_W-1:0] stall_q, flush_q;

  assign stall_evt = (cur_state == STALL) | ((cur_state == RUN) & ~mispredict & load_use);
  assign flush_evt = (cur_state == RUN) & mispredict;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt && (stall_q != {CNT_W{1'b1}})) stall_q <= stall_q + 1'b1;
      if (flush_evt && (flush_q != {CNT_W{1'b1}})) flush_q <= flush_q + 1'b1;
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
